// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths and opcode encodings.
// Used by the fetch stage and the control FSM downstream of it.
package cpu_pkg;

    localparam int OP_SIZE  = 4;
    localparam int ARG_SIZE = 3;
    localparam int ARG_NUM  = 2;
    localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE;

    typedef enum logic [OP_SIZE-1:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_JMP  = 4'h6,
        OP_HALT = 4'hF
    } opcode_t;

    // Opcode field of an instruction word (top OP_SIZE bits).
    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_t'(instr[INSTR_W-1 -: OP_SIZE]);
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Writable program store: 2**ADDR_W words of DATA_W bits.
// Ports:
//   clk            rising-edge clock
//   we/waddr/wdata synchronous write port
//   re/raddr       read request; rdata is valid the cycle after re
//   rdata          registered read data
// Contents are never reset. A read and a write to the same address on
// one edge return the old word.
module instr_rom #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage with prefetch queue.
// Walks a PC through instr_rom and keeps up to DEPTH fetched words so the
// control FSM always sees the next instruction at the queue head.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   prog_we/addr/data  program load; flushes the queue and holds pc at 0
//   branch, branch_address  one-cycle redirect; flushes the queue
//   done            FSM retires the head entry
//   instruction     queue head (0 when empty), valid = queue non-empty
//   pc              next address to be read
//   count           queue occupancy
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int OP_SIZE  = cpu_pkg::OP_SIZE,
    parameter int ARG_SIZE = cpu_pkg::ARG_SIZE,
    parameter int ARG_NUM  = cpu_pkg::ARG_NUM,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 2,
    localparam int INSTR_W = OP_SIZE + ARG_NUM * ARG_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_we,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [INSTR_W-1:0]         prog_data,
    input  logic                       branch,
    input  logic [ADDR_W-1:0]          branch_address,
    input  logic                       done,
    output logic [INSTR_W-1:0]         instruction,
    output logic                       valid,
    output logic [ADDR_W-1:0]          pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_V = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    logic [INSTR_W-1:0] queue [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   cnt;
    logic               inflight;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] rom_data;

    logic               flush;
    logic               push;
    logic               pop;
    logic               issue;
    logic [CNT_W:0]     occ;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        flush = prog_we || branch;
        push  = inflight && !flush;
        pop   = done && (cnt != '0) && !flush;
        // A pop frees its slot on the same edge, so it counts toward the
        // issue check; this keeps the queue streaming without bubbles.
        occ   = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        issue = !flush && (occ < DEPTH_V);
    end

    instr_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_rom (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (issue),
        .raddr (pc_q),
        .rdata (rom_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else if (prog_we) begin
            pc_q     <= '0;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else if (branch) begin
            pc_q     <= branch_address;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc_q <= pc_q + 1'b1;
            end
            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[tail] <= rom_data;
        end
    end

    assign valid       = (cnt != '0);
    assign instruction = valid ? queue[head] : '0;
    assign pc          = pc_q;
    assign count       = cnt;

endmodule
